// File: rtl/i2c_slave_wb.sv
// I2C target (7-bit addressing) with an 8-byte register file, controlled and
// observed over a Wishbone classic slave port.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   wb_stb_i/cyc_i/we_i Wishbone strobe, cycle, write enable
//   wb_adr_i            byte address, decoded on [5:2]
//   wb_sel_i            byte selects (unused)
//   wb_dat_i / wb_dat_o write data ([7:0] used) / registered read data
//   wb_ack_o            one acknowledge per access
//   i2c_scl             bus clock from the external master
//   i2c_sda             open-drain data line, driven only to 0 or released
//
// Register map (wb_adr_i[5:2]):
//   0     status {busy, rw, stop_seen, wr_event}; write-1-to-clear [1:0]
//   1     own address (7 bits)
//   2     register pointer (3 bits, read only)
//   8-15  regfile[0..7]
module i2c_slave_wb #(
    parameter logic [6:0] OWN_ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        i2c_scl,
    inout  wire         i2c_sda
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t      state_q;
    logic [2:0]  scl_sync_q, sda_sync_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q, tx_q;
    logic        sda_oe_q, mack_q;
    logic [2:0]  pointer_q, ptr_inc;
    logic        busy_q, rw_q, stop_seen_q, wr_event_q;
    logic [6:0]  own_addr_q;
    logic [7:0]  regfile_q [8];
    logic        ack_wb_q;
    logic [7:0]  wb_dat_q, rd_data_d, cur_byte, nxt_byte;
    logic        scl_s, scl_prev, sda_s, sda_prev;
    logic        scl_rise, scl_fall, start_det, stop_det;
    logic        wb_req, wb_wr, i2c_wr_fire;
    logic [7:0]  wb_reg_we, i2c_reg_we;
    logic        unused_inputs;

    assign unused_inputs = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i[31:8]};

    // Plain synchronizers: left unreset so that reset never fabricates
    // a bus edge; the FSM ignores the bus in IDLE anyway.
    always_ff @(posedge clk) begin
        scl_sync_q <= {scl_sync_q[1:0], i2c_scl};
        sda_sync_q <= {sda_sync_q[1:0], i2c_sda};
    end

    assign scl_s     = scl_sync_q[1];
    assign scl_prev  = scl_sync_q[2];
    assign sda_s     = sda_sync_q[1];
    assign sda_prev  = sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
    assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_wb_q;
    assign wb_dat_o = {24'h0, wb_dat_q};

    assign wb_req  = wb_stb_i & wb_cyc_i & ~ack_wb_q;
    assign wb_wr   = wb_req & wb_we_i;
    assign ptr_inc = pointer_q + 3'd1;
    assign cur_byte = regfile_q[pointer_q];
    assign nxt_byte = regfile_q[ptr_inc];

    // The data byte is committed on the falling edge that starts its ACK slot.
    assign i2c_wr_fire = ~stop_det & ~start_det & scl_fall &
                         (state_q == S_WR_DATA) & (bit_cnt_q == 4'd8);

    for (genvar gi = 0; gi < 8; gi++) begin : g_we
        assign wb_reg_we[gi]  = wb_wr & wb_adr_i[5] & (wb_adr_i[4:2] == 3'(gi));
        assign i2c_reg_we[gi] = i2c_wr_fire & (pointer_q == 3'(gi));
    end

    always_comb begin
        rd_data_d = 8'h00;
        case (wb_adr_i[5:2])
            4'd0:    rd_data_d = {4'b0, busy_q, rw_q, stop_seen_q, wr_event_q};
            4'd1:    rd_data_d = {1'b0, own_addr_q};
            4'd2:    rd_data_d = {5'b0, pointer_q};
            default: if (wb_adr_i[5]) rd_data_d = regfile_q[wb_adr_i[4:2]];
        endcase
    end

    // I2C write takes priority over a Wishbone write to the same byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (reset)              regfile_q[i] <= 8'h00;
            else if (i2c_reg_we[i]) regfile_q[i] <= shift_q;
            else if (wb_reg_we[i])  regfile_q[i] <= wb_dat_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            sda_oe_q    <= 1'b0;
            mack_q      <= 1'b1;
            pointer_q   <= 3'd0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            stop_seen_q <= 1'b0;
            wr_event_q  <= 1'b0;
            own_addr_q  <= OWN_ADDR;
            ack_wb_q    <= 1'b0;
            wb_dat_q    <= 8'h00;
        end else begin
            ack_wb_q <= wb_req;
            if (wb_req) wb_dat_q <= rd_data_d;
            if (wb_wr && wb_adr_i[5:2] == 4'd0) begin
                if (wb_dat_i[0]) wr_event_q  <= 1'b0;
                if (wb_dat_i[1]) stop_seen_q <= 1'b0;
            end
            if (wb_wr && wb_adr_i[5:2] == 4'd1) own_addr_q <= wb_dat_i[6:0];

            // Bus-side updates come later so they win over status clears.
            if (stop_det) begin
                state_q  <= S_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                if (busy_q) stop_seen_q <= 1'b1;
            end else if (start_det) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_PTR, S_WR_DATA: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= 4'd0;
                            if (state_q == S_ADDR) begin
                                if (shift_q[7:1] == own_addr_q) begin
                                    sda_oe_q <= 1'b1;
                                    busy_q   <= 1'b1;
                                    rw_q     <= shift_q[0];
                                    state_q  <= S_ADDR_ACK;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= S_WAIT_STOP;
                                end
                            end else if (state_q == S_PTR) begin
                                pointer_q <= shift_q[2:0];
                                sda_oe_q  <= 1'b1;
                                state_q   <= S_PTR_ACK;
                            end else begin
                                wr_event_q <= 1'b1;
                                sda_oe_q   <= 1'b1;
                                state_q    <= S_WR_ACK;
                            end
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        if (rw_q) begin
                            tx_q     <= cur_byte;
                            sda_oe_q <= ~cur_byte[7];
                            state_q  <= S_RD_DATA;
                        end else begin
                            sda_oe_q <= 1'b0;
                            state_q  <= S_PTR;
                        end
                    end
                    S_PTR_ACK: if (scl_fall) begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_WR_DATA;
                    end
                    S_WR_ACK: if (scl_fall) begin
                        sda_oe_q  <= 1'b0;
                        pointer_q <= ptr_inc;
                        state_q   <= S_WR_DATA;
                    end
                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= S_RD_ACK;
                            end else begin
                                tx_q     <= {tx_q[6:0], 1'b0};
                                sda_oe_q <= ~tx_q[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            mack_q <= sda_s;
                        end else if (scl_fall) begin
                            if (!mack_q) begin
                                pointer_q <= ptr_inc;
                                tx_q      <= nxt_byte;
                                sda_oe_q  <= ~nxt_byte[7];
                                state_q   <= S_RD_DATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= S_WAIT_STOP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
